mem_wb_stage: RTL

Memory-access stage of the 5-stage pipelined RISC processor. It consumes the EX/MEM register outputs of the ALU stage (`ExMem_*`) and holds the word-addressed data memory and the MEM/WB pipeline register. It drives the writeback mux (`Dst_FeedBack`) and resolves branches and jumps (`Flush`). It also contains the forwarding unit that generates `FwdRs`/`FwdRt` back into the ALU stage, closing the EX-stage forwarding loop from the consumer side.

---
 rtl/mem_wb_stage.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage
//
// Memory-access stage of the 5-stage pipelined RISC core. It holds the
// word-addressed data memory and the MEM/WB pipeline register. It drives the
// writeback mux and resolves branches and jumps. It also hosts the forwarding
// unit that selects the ALU-stage operand sources.
//
// Parameters
//   DEPTH : data-memory depth in 32-bit words (power of 2)
//   AW    : word-index width, log2(DEPTH)
//
// Ports
//   CLK, RST            clock (rising edge); synchronous active-high reset
//   ExMem_*             EX/MEM pipeline register contents (instruction in MEM)
//   IdEx_AddrRs/Rt      source registers of the instruction currently in EX
//   Flush, PCSrc        branch/jump resolution, combinational
//   FwdRs, FwdRt        operand selects: 10 EX/MEM, 01 MEM/WB, 00 register file
//   Dst_FeedBack        writeback data (register file + ALU forwarding mux)
//   MemWb_*             MEM/WB pipeline register contents
// ----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ExMem_Jump,
   input  logic        ExMem_Branch,
   input  logic        ExMem_MemRead,
   input  logic        ExMem_MemtoReg,
   input  logic        ExMem_MemWrite,
   input  logic        ExMem_RegWrite,
   input  logic [31:0] ExMem_DataRt,
   input  logic [4:0]  ExMem_AddrRdRt,
   input  logic [31:0] ExMem_AluOut,
   input  logic        ExMem_ZeroFlag,
   input  logic [4:0]  IdEx_AddrRs,
   input  logic [4:0]  IdEx_AddrRt,
   output logic        Flush,
   output logic        PCSrc,
   output logic [1:0]  FwdRs,
   output logic [1:0]  FwdRt,
   output logic [31:0] Dst_FeedBack,
   output logic        MemWb_RegWrite,
   output logic [4:0]  MemWb_AddrRd,
   output logic [31:0] MemWb_ReadData,
   output logic [31:0] MemWb_AluOut
);

   // Forwarding select for one operand. The newer producer (EX/MEM) wins over
   // MEM/WB. A destination of r0 never forwards. A load sitting in MEM still
   // selects 2'b10 here; holding off a load-use consumer is the hazard unit's
   // job.
   function automatic logic [1:0] fwdSelect(
      input logic       exWrite,
      input logic [4:0] exDst,
      input logic       wbWrite,
      input logic [4:0] wbDst,
      input logic [4:0] srcReg
   );
      logic [1:0] sel;
      if (exWrite && (exDst != 5'd0) && (exDst == srcReg)) begin
         sel = 2'b10;
      end else if (wbWrite && (wbDst != 5'd0) && (wbDst == srcReg)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [31:0]   dataMem_r [DEPTH];
   logic          memWbRegWrite_r;
   logic          memWbMemtoReg_r;
   logic [4:0]    memWbAddrRd_r;
   logic [31:0]   memWbReadData_r;
   logic [31:0]   memWbAluOut_r;

   // ------------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------------
   logic [AW-1:0] memIdx_s;
   logic [31:0]   memRdData_s;
   logic          pcSrc_s;
   logic          flush_s;
   logic [1:0]    fwdRs_s;
   logic [1:0]    fwdRt_s;
   logic [31:0]   dstFeedBack_s;
   logic          unusedInputs_s;

   // The byte offset and the bits above the memory size are dropped, so
   // addresses wrap modulo 4*DEPTH bytes.
   assign memIdx_s    = ExMem_AluOut[AW+1:2];

   // Asynchronous read. At an edge that also writes the same word, the old
   // content is what gets captured into MEM/WB.
   assign memRdData_s = dataMem_r[memIdx_s];

   // ExMem_MemRead is not needed: the read word is captured every cycle and
   // MemtoReg decides whether it reaches the register file.
   assign unusedInputs_s = ExMem_MemRead;

   // Data memory: reset clears every word; otherwise perform the store.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            dataMem_r[i] <= 32'h0000_0000;
         end
      end else if (ExMem_MemWrite) begin
         dataMem_r[memIdx_s] <= ExMem_DataRt;
      end else begin
         dataMem_r[memIdx_s] <= dataMem_r[memIdx_s];
      end
   end

   // MEM/WB pipeline register: free-running capture with no stall or enable.
   always_ff @(posedge CLK) begin
      if (RST) begin
         memWbRegWrite_r <= 1'b0;
         memWbMemtoReg_r <= 1'b0;
         memWbAddrRd_r   <= 5'd0;
         memWbReadData_r <= 32'h0000_0000;
         memWbAluOut_r   <= 32'h0000_0000;
      end else begin
         memWbRegWrite_r <= ExMem_RegWrite;
         memWbMemtoReg_r <= ExMem_MemtoReg;
         memWbAddrRd_r   <= ExMem_AddrRdRt;
         memWbReadData_r <= memRdData_s;
         memWbAluOut_r   <= ExMem_AluOut;
      end
   end

   // Branch/jump resolution, writeback mux and forwarding selects.
   // The instruction in MEM is not squashed by its own Flush.
   always_comb begin
      pcSrc_s       = 1'b0;
      flush_s       = 1'b0;
      dstFeedBack_s = 32'h0000_0000;
      fwdRs_s       = 2'b00;
      fwdRt_s       = 2'b00;

      pcSrc_s = ExMem_Branch & ExMem_ZeroFlag;
      flush_s = pcSrc_s | ExMem_Jump;

      if (memWbMemtoReg_r) begin
         dstFeedBack_s = memWbReadData_r;
      end else begin
         dstFeedBack_s = memWbAluOut_r;
      end

      fwdRs_s = fwdSelect(ExMem_RegWrite, ExMem_AddrRdRt,
                          memWbRegWrite_r, memWbAddrRd_r, IdEx_AddrRs);
      fwdRt_s = fwdSelect(ExMem_RegWrite, ExMem_AddrRdRt,
                          memWbRegWrite_r, memWbAddrRd_r, IdEx_AddrRt);
   end

   assign PCSrc          = pcSrc_s;
   assign Flush          = flush_s;
   assign FwdRs          = fwdRs_s;
   assign FwdRt          = fwdRt_s;
   assign Dst_FeedBack   = dstFeedBack_s;
   assign MemWb_RegWrite = memWbRegWrite_r;
   assign MemWb_AddrRd   = memWbAddrRd_r;
   assign MemWb_ReadData = memWbReadData_r;
   assign MemWb_AluOut   = memWbAluOut_r;

endmodule
